// File: rtl/noc_mux.sv
// noc_mux: packet-level round-robin multiplexer of CHANNELS flit streams
// onto one output link. Once a packet is granted, the grant holds until its
// last flit transfers, so packets are never interleaved on the output.
//
// Ports:
//   clk        clock; all state updates on posedge
//   rst_n      asynchronous, active-low reset
//   in_flit    CHANNELS payloads, channel i at [i*FLIT_WIDTH +: FLIT_WIDTH]
//   in_last    per-channel last-flit-of-packet flag
//   in_valid   per-channel flit valid
//   in_ready   per-channel accept, at most one bit set per cycle
//   out_flit   selected payload (zero when out_valid=0)
//   out_last   selected last flag (zero when out_valid=0)
//   out_valid  output valid
//   out_ready  downstream accept
//
// The datapath is purely combinational: zero latency, no flit storage.
module noc_mux #(
  parameter int FLIT_WIDTH = 32,
  parameter int CHANNELS   = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [CHANNELS*FLIT_WIDTH-1:0] in_flit,
  input  logic [CHANNELS-1:0]            in_last,
  input  logic [CHANNELS-1:0]            in_valid,
  output logic [CHANNELS-1:0]            in_ready,
  output logic [FLIT_WIDTH-1:0]          out_flit,
  output logic                           out_last,
  output logic                           out_valid,
  input  logic                           out_ready
);

  localparam int GW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  if (CHANNELS < 2) begin : g_bad_channels
    $fatal(1, "noc_mux: CHANNELS must be >= 2");
  end

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t        state, state_next;
  logic [GW-1:0] gnt, gnt_next;
  logic [GW-1:0] ptr, ptr_next;
  logic [GW-1:0] sel, sel_inc;
  logic          xfer;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      gnt   <= '0;
      ptr   <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values of the others, independent of statement order.
      state <= state_next;
      gnt   <= gnt_next;
      ptr   <= ptr_next;
    end
  end

  // Channel selection. In IDLE, search ptr, ptr+1, ... with an explicit
  // modulo wrap so non-power-of-2 channel counts never reach an unused index.
  // In ACTIVE the owner of the packet in flight is the only candidate.
  always_comb begin
    int  idx;
    logic found;
    // NOTE: every variable written in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    sel   = ptr;
    found = 1'b0;
    idx   = 0;
    if (state == ACTIVE) begin
      sel = gnt;
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        idx = int'(ptr) + k;
        if (idx >= CHANNELS) idx = idx - CHANNELS;
        if (!found && in_valid[idx]) begin
          sel   = GW'(idx);
          found = 1'b1;
        end
      end
    end
  end

  assign sel_inc = (sel == GW'(CHANNELS - 1)) ? '0 : sel + 1'b1;
  assign xfer    = out_valid & out_ready;

  // Next-state logic.
  always_comb begin
    state_next = state;
    gnt_next   = gnt;
    ptr_next   = ptr;
    case (state)
      IDLE: begin
        if (out_valid) begin
          if (xfer && out_last) begin
            // Single-flit packet done in one cycle; rotate priority.
            ptr_next = sel_inc;
          end else begin
            // Freeze the choice even if the head flit stalled, so a
            // presented flit is never swapped for another channel's flit.
            gnt_next   = sel;
            state_next = ACTIVE;
          end
        end
      end
      ACTIVE: begin
        if (xfer && out_last) begin
          state_next = IDLE;
          ptr_next   = sel_inc;  // sel == gnt while ACTIVE
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output logic. Gated by rst_n so nothing is presented while in reset.
  always_comb begin
    out_valid = 1'b0;
    out_flit  = '0;
    out_last  = 1'b0;
    in_ready  = '0;
    if (rst_n && in_valid[sel]) begin
      out_valid     = 1'b1;
      out_flit      = in_flit[sel*FLIT_WIDTH +: FLIT_WIDTH];
      out_last      = in_last[sel];
      in_ready[sel] = out_ready;
    end
  end

endmodule

// File: tb/tb_noc_mux.sv
// tb_noc_mux: self-checking bench for noc_mux with three channels, so the
// round-robin pointer wraps over a non-power-of-2 count. Each upstream
// channel is a queue of flits; a packet-level reference model decides every
// cycle which channel owns the link and which flit moves, pushes each
// expected transfer into a scoreboard queue, and a separate monitor pops and
// compares whenever the DUT completes a handshake.
module tb_noc_mux;

  localparam int N = 3;
  localparam int W = 32;

  typedef struct {
    logic [W-1:0] data;
    logic         last;
    int           ch;
  } item_t;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N*W-1:0] in_flit;
  logic [N-1:0]   in_last;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [W-1:0]   out_flit;
  logic           out_last;
  logic           out_valid;
  logic           out_ready;

  int n_vec = 0;
  int n_err = 0;

  item_t src[N][$];   // upstream per-channel flit queues
  item_t exp_q[$];    // scoreboard of expected transfers
  item_t mon_item;
  int    pkt_id = 0;

  // Reference model: owner = channel holding the link (-1 none),
  // prio = channel with highest priority at the next arbitration.
  int owner = -1;
  int prio  = 0;

  noc_mux #(.FLIT_WIDTH(W), .CHANNELS(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_flit   (in_flit),
    .in_last   (in_last),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_flit  (out_flit),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_flit(input int ch, input logic [W-1:0] data, input logic last);
    item_t it;
    it.data = data;
    it.last = last;
    it.ch   = ch;
    src[ch].push_back(it);
  endtask

  task automatic add_pkt(input int ch, input int len);
    for (int i = 0; i < len; i++)
      push_flit(ch, {8'(ch), 8'(pkt_id), 8'(i), 8'($urandom)}, (i == len - 1));
    pkt_id++;
  endtask

  // One clock of stimulus: present queue heads on enabled channels, let the
  // model decide the outcome, and advance the upstream queues accordingly.
  task automatic step(input logic [N-1:0] en, input logic rdy);
    int   cand;
    logic vld;
    item_t it;
    @(posedge clk);
    #1;
    out_ready = rdy;
    for (int c = 0; c < N; c++) begin
      in_valid[c] = en[c] && (src[c].size() > 0);
      if (in_valid[c]) begin
        in_flit[c*W +: W] = src[c][0].data;
        in_last[c]        = src[c][0].last;
      end else begin
        in_flit[c*W +: W] = $urandom;
        in_last[c]        = 1'($urandom);
      end
    end
    cand = -1;
    if (owner >= 0) begin
      cand = owner;
    end else begin
      for (int k = 0; k < N; k++) begin
        int c2;
        c2 = (prio + k) % N;
        if (cand < 0 && in_valid[c2]) cand = c2;
      end
    end
    vld = (cand >= 0) && in_valid[cand];
    if (vld && rdy) begin
      it = src[cand].pop_front();
      exp_q.push_back(it);
      if (it.last) begin
        owner = -1;
        prio  = (cand + 1) % N;
      end else begin
        owner = cand;
      end
    end else if (vld) begin
      owner = cand;
    end
  endtask

  // Reset with every input valid; outputs must stay quiet throughout.
  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n     = 1'b0;
    in_valid  = '1;
    in_last   = '1;
    in_flit   = {$urandom, $urandom, $urandom};
    out_ready = 1'b1;
    for (int c = 0; c < N; c++) src[c].delete();
    owner = -1;
    prio  = 0;
    @(posedge clk);
    #2;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, '0);
    check("rst_out_flit", out_flit, '0);
    check("rst_out_last", out_last, 1'b0);
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    in_valid = '0;
  endtask

  // Monitor: compare every DUT handshake against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("spurious_xfer", out_valid, 1'b0);
        end else begin
          mon_item = exp_q.pop_front();
          check("sb_flit", out_flit, mon_item.data);
          check("sb_last", out_last, mon_item.last);
          check("sb_grant", in_ready, 64'(1 << mon_item.ch));
        end
      end else begin
        check("idle_in_ready", in_ready, '0);
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = '0;
    in_flit   = '0;
    in_last   = '0;
    out_ready = 1'b0;

    // Reset with all requesters valid, then ch0 wins first (ptr=0).
    do_reset();
    add_pkt(0, 1);
    add_pkt(1, 1);
    add_pkt(2, 1);
    step('1, 1'b1);
    #2;
    check("first_grant", in_ready, 3'b001);
    repeat (2) step('1, 1'b1);

    // Interleave block: A0..A3 then B0..B1 with no gaps.
    do_reset();
    add_pkt(0, 4);
    add_pkt(1, 2);
    for (int i = 0; i < 6; i++) begin
      step(3'b011, 1'b1);
      #2;
      check("ilv_valid", out_valid, 1'b1);
    end

    // Round robin over three channels of single-flit packets.
    do_reset();
    for (int c = 0; c < N; c++)
      for (int j = 0; j < 4; j++) add_pkt(c, 1);
    for (int i = 0; i < 12; i++) begin
      step('1, 1'b1);
      #2;
      check("rr_grant", in_ready, 64'(1 << (i % N)));
    end

    // Backpressure at head: ch1's stalled flit stays presented after ch0 wakes.
    do_reset();
    push_flit(1, 32'h11, 1'b1);
    add_pkt(0, 1);
    for (int i = 0; i < 3; i++) begin
      step(3'b010, 1'b0);
      #2;
      check("bp_flit", out_flit, 32'h11);
      check("bp_valid", out_valid, 1'b1);
    end
    step(3'b011, 1'b0);
    #2;
    check("bp_hold_flit", out_flit, 32'h11);
    check("bp_hold_ready", in_ready, 3'b000);
    step(3'b011, 1'b1);
    #2;
    check("bp_xfer_ready", in_ready, 3'b010);
    check("bp_xfer_flit", out_flit, 32'h11);
    step(3'b011, 1'b1);
    #2;
    check("bp_next_ready", in_ready, 3'b001);

    // Mid-packet bubble on ch0 while ch1 waits.
    do_reset();
    add_pkt(0, 3);
    add_pkt(1, 2);
    step(3'b011, 1'b1);
    #2;
    check("bub_first", in_ready, 3'b001);
    for (int i = 0; i < 2; i++) begin
      step(3'b010, 1'b1);
      #2;
      check("bub_valid", out_valid, 1'b0);
      check("bub_ready", in_ready, 3'b000);
    end
    step(3'b011, 1'b1);
    #2;
    check("bub_resume", in_ready, 3'b001);
    step(3'b011, 1'b1);
    #2;
    check("bub_last_ready", in_ready, 3'b001);
    check("bub_last_flag", out_last, 1'b1);
    step(3'b011, 1'b1);
    #2;
    check("bub_ch1", in_ready, 3'b010);
    step(3'b011, 1'b1);

    // Reset mid-packet with ptr moved off zero beforehand.
    do_reset();
    add_pkt(0, 1);
    add_pkt(1, 5);
    repeat (3) step(3'b011, 1'b1);
    do_reset();
    step('0, 1'b1);
    #2;
    check("rst_mid_valid", out_valid, 1'b0);
    check("rst_mid_flit", out_flit, '0);
    add_pkt(1, 1);
    add_pkt(0, 1);
    step('1, 1'b1);
    #2;
    check("rst_mid_ptr0", in_ready, 3'b001);
    step('1, 1'b1);

    // Randomized traffic: varied packet lengths, bubbles and backpressure.
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic [N-1:0] en;
      for (int c = 0; c < N; c++) begin
        if (src[c].size() < 4 && $urandom_range(3) == 0)
          add_pkt(c, 1 + $urandom_range(3));
        en[c] = ($urandom_range(99) < 85);
      end
      step(en, $urandom_range(9) < 7);
    end
    for (int i = 0; i < 500; i++) begin
      if (src[0].size() + src[1].size() + src[2].size() > 0) step('1, 1'b1);
    end

    @(negedge clk);
    #1;
    check("sb_drained", 64'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
